instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem request,
// IF/ID pipeline register, and hold buffer for words returned under stall.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opcode
);

  typedef enum logic [1:0] {FETCH, HELD, DROP} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic        ack_ok;
  logic [31:0] pc_inc;
  logic [31:0] target;

  // req_q stays low through the first cycle after reset so a stale ack from
  // an abandoned pre-reset request is never mistaken for a new response.
  assign ack_ok = imem_ack & req_q;
  assign pc_inc = pc_q + 32'd4;
  assign target = branch_target & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    hold_d  = hold_q;
    if (branch_taken) begin
      pc_d    = target;
      valid_d = 1'b0;
      hold_d  = '0;
      case (state_q)
        FETCH:   state_d = (req_q && !imem_ack) ? DROP : FETCH;
        HELD:    state_d = FETCH;
        default: state_d = imem_ack ? FETCH : DROP;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (ack_ok) begin
            if (!stall) begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              pc4_d   = pc_inc;
              pc_d    = pc_inc;
            end else begin
              hold_d  = imem_rdata;
              state_d = HELD;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HELD: begin
          if (!stall) begin
            valid_d = 1'b1;
            instr_d = hold_q;
            pc4_d   = pc_inc;
            pc_d    = pc_inc;
            state_d = FETCH;
          end
        end
        default: begin
          if (imem_ack) state_d = FETCH;
        end
      endcase
    end
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign opcode      = instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch, plus hand sequences for
// async reset mid-HELD, late ack after reset, and PC wrap-around.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack, stall, branch_taken;
  logic [31:0] imem_rdata, branch_target;

  logic        req0, req1, valid0, valid1;
  logic [31:0] addr0, addr1, instr0, instr1, pc40, pc41;
  logic [5:0]  op0, op1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  instr_fetch u0 (
    .clk(clk), .rst_n(rst_n), .imem_req(req0), .imem_addr(addr0),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(valid0), .if_id_instr(instr0), .if_id_pc4(pc40), .opcode(op0)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst_n(rst_n), .imem_req(req1), .imem_addr(addr1),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(valid1), .if_id_instr(instr1), .if_id_pc4(pc41), .opcode(op1)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic a, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep);
    vec_t v;
    v.stall = s;  v.br = b;  v.tgt = t;  v.ack = a;  v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic a, input logic [31:0] rd);
    stall = s; branch_taken = b; branch_target = t; imem_ack = a; imem_rdata = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_u0(input string tag, input logic er, input logic [31:0] ea,
                        input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    logic [31:0] ei_v;
    ei_v = ei;
    chk({tag, " req"},    {31'b0, req0},   {31'b0, er});
    chk({tag, " addr"},   addr0,           ea);
    chk({tag, " valid"},  {31'b0, valid0}, {31'b0, ev});
    chk({tag, " instr"},  instr0,          ei);
    chk({tag, " pc4"},    pc40,            ep);
    chk({tag, " opcode"}, {26'b0, op0},    {26'b0, ei_v[31:26]});
  endtask

  initial begin
    // Streaming, stall/HELD, redirect in flight, branch+stall in HELD,
    // branch with ack in FETCH, repeated branch in DROP.
    vecs[0]  = mk(0, 0, 0,      1, 32'h0400_0000, 1, 32'h004, 1, 32'h0400_0000, 32'h004);
    vecs[1]  = mk(0, 0, 0,      1, 32'h0800_0004, 1, 32'h008, 1, 32'h0800_0004, 32'h008);
    vecs[2]  = mk(1, 0, 0,      1, 32'h0C00_0008, 0, 32'h008, 1, 32'h0800_0004, 32'h008);
    vecs[3]  = mk(1, 0, 0,      0, 32'h0,         0, 32'h008, 1, 32'h0800_0004, 32'h008);
    vecs[4]  = mk(1, 0, 0,      0, 32'h0,         0, 32'h008, 1, 32'h0800_0004, 32'h008);
    vecs[5]  = mk(0, 0, 0,      0, 32'h0,         1, 32'h00C, 1, 32'h0C00_0008, 32'h00C);
    vecs[6]  = mk(0, 0, 0,      0, 32'h0,         1, 32'h00C, 0, 32'h0C00_0008, 32'h00C);
    vecs[7]  = mk(0, 0, 0,      1, 32'h1000_000C, 1, 32'h010, 1, 32'h1000_000C, 32'h010);
    vecs[8]  = mk(0, 1, 32'h103, 0, 32'h0,        0, 32'h100, 0, 32'h1000_000C, 32'h010);
    vecs[9]  = mk(0, 0, 0,      1, 32'hDEAD_BEEF, 1, 32'h100, 0, 32'h1000_000C, 32'h010);
    vecs[10] = mk(0, 0, 0,      1, 32'h1400_0100, 1, 32'h104, 1, 32'h1400_0100, 32'h104);
    vecs[11] = mk(1, 0, 0,      1, 32'h1800_0104, 0, 32'h104, 1, 32'h1400_0100, 32'h104);
    vecs[12] = mk(1, 1, 32'h040, 0, 32'h0,        1, 32'h040, 0, 32'h1400_0100, 32'h104);
    vecs[13] = mk(0, 0, 0,      1, 32'h1C00_0040, 1, 32'h044, 1, 32'h1C00_0040, 32'h044);
    vecs[14] = mk(0, 1, 32'h200, 1, 32'hBAD0_BAD0, 1, 32'h200, 0, 32'h1C00_0040, 32'h044);
    vecs[15] = mk(0, 1, 32'h080, 0, 32'h0,        0, 32'h080, 0, 32'h1C00_0040, 32'h044);
    vecs[16] = mk(0, 1, 32'h084, 0, 32'h0,        0, 32'h084, 0, 32'h1C00_0040, 32'h044);
    vecs[17] = mk(0, 0, 0,      1, 32'hBADB_AD00, 1, 32'h084, 0, 32'h1C00_0040, 32'h044);
    vecs[18] = mk(0, 0, 0,      1, 32'h2000_0084, 1, 32'h088, 1, 32'h2000_0084, 32'h088);
    vecs[19] = mk(1, 0, 0,      0, 32'h0,         1, 32'h088, 1, 32'h2000_0084, 32'h088);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk_u0("reset", 0, 32'h0, 0, 32'h0, 32'h0);
    chk("reset u1 addr", addr1, 32'hFFFF_FFFC);

    #8 rst_n = 1'b1;
    #2;
    chk("post-reset pre-edge req", {31'b0, req0}, 32'h0);
    tick;
    chk_u0("first req", 1, 32'h0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
      tick;
      chk_u0($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
             vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc4);
    end

    // Enter HELD, then assert reset between clock edges.
    drive(1, 0, 0, 1, 32'h2400_0088);
    tick;
    chk_u0("held", 0, 32'h088, 1, 32'h2000_0084, 32'h088);
    #3 rst_n = 1'b0;
    #1;
    chk_u0("async reset", 0, 32'h0, 0, 32'h0, 32'h0);
    chk("async reset u1 addr", addr1, 32'hFFFF_FFFC);

    // Late ack straddling reset release must be ignored.
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    #2 rst_n = 1'b1;
    tick;
    chk_u0("late ack ignored", 1, 32'h0, 0, 32'h0, 32'h0);

    drive(0, 0, 0, 1, 32'h2800_0000);
    tick;
    chk_u0("after reset fetch", 1, 32'h004, 1, 32'h2800_0000, 32'h004);
    chk("wrap u1 pc4",   pc41,             32'h0);
    chk("wrap u1 addr",  addr1,            32'h0);
    chk("wrap u1 valid", {31'b0, valid1},  32'h1);
    chk("wrap u1 instr", instr1,           32'h2800_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
